// File: rtl/data_mem_controller_pkg.sv
// Shared types for the data-memory controller.
//   data_t / data_memory_address_t : default word and address types of the core
//   mem_channel_state_t            : per-channel transaction state
//   id_width()                     : width of a consumer id (at least one bit)
package data_mem_controller_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] data_memory_address_t;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_READ_WAIT,
    CH_WRITE_WAIT,
    CH_RELEASE
  } mem_channel_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_controller_mem_channel.sv
// One data-memory channel: transaction FSM, owner register and the registered
// memory-side request outputs.
//   grant / grant_id / grant_is_read / grant_addr / grant_wdata : new request from the arbiter
//   owner_active  : owner still holds read_valid or write_valid
//   mem_*         : memory port of this channel
//   owner         : consumer currently owning the channel
//   idle          : channel may accept a grant this cycle
//   rd_done / wr_done : memory handshake completes this cycle
//   release_done  : owner has dropped its valids; busy bit can be cleared
module mem_channel
  import data_mem_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = $bits(data_memory_address_t),
  parameter int DATA_WIDTH = $bits(data_t),
  parameter int ID_W       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  grant,
  input  logic                  grant_is_read,
  input  logic [ID_W-1:0]       grant_id,
  input  logic [ADDR_WIDTH-1:0] grant_addr,
  input  logic [DATA_WIDTH-1:0] grant_wdata,
  input  logic                  owner_active,
  output logic                  mem_read_valid,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic                  mem_read_ready,
  output logic                  mem_write_valid,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write_ready,
  output logic [ID_W-1:0]       owner,
  output logic                  idle,
  output logic                  rd_done,
  output logic                  wr_done,
  output logic                  release_done
);

  mem_channel_state_t state, state_next;

  // Set on the grant edge; the request reaches the memory port one cycle later.
  logic                  issue_pending;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  assign idle = (state == CH_IDLE);

  // A ready only counts while this channel's own request is visible on the port.
  assign rd_done      = (state == CH_READ_WAIT)  && mem_read_valid  && mem_read_ready;
  assign wr_done      = (state == CH_WRITE_WAIT) && mem_write_valid && mem_write_ready;
  assign release_done = (state == CH_RELEASE)    && !owner_active;

  always_ff @(posedge clk) begin
    if (reset) state <= CH_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CH_IDLE:       if (grant) state_next = grant_is_read ? CH_READ_WAIT : CH_WRITE_WAIT;
      CH_READ_WAIT:  if (rd_done) state_next = CH_RELEASE;
      CH_WRITE_WAIT: if (wr_done) state_next = CH_RELEASE;
      CH_RELEASE:    if (release_done) state_next = CH_IDLE;
      default:       state_next = CH_IDLE;
    endcase
  end

  // Request payload is captured at the grant edge; no reset needed.
  always_ff @(posedge clk) begin
    if (idle && grant) begin
      req_addr  <= grant_addr;
      req_wdata <= grant_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner           <= '0;
      issue_pending   <= 1'b0;
      mem_read_valid  <= 1'b0;
      mem_read_addr   <= '0;
      mem_write_valid <= 1'b0;
      mem_write_addr  <= '0;
      mem_write_data  <= '0;
    end else begin
      if (idle && grant) begin
        owner         <= grant_id;
        issue_pending <= 1'b1;
      end
      if (issue_pending) begin
        issue_pending <= 1'b0;
        if (state == CH_READ_WAIT) begin
          mem_read_valid <= 1'b1;
          mem_read_addr  <= req_addr;
        end else begin
          mem_write_valid <= 1'b1;
          mem_write_addr  <= req_addr;
          mem_write_data  <= req_wdata;
        end
      end
      if (rd_done) mem_read_valid  <= 1'b0;
      if (wr_done) mem_write_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_controller.sv
// Arbitrates NUM_CONSUMERS LSU read/write requests onto NUM_CHANNELS
// data-memory ports, one transaction in flight per channel.
//   consumer_read_*  : per-LSU read request in, registered ready pulse and data out
//   consumer_write_* : per-LSU write request in, registered ready pulse out
//   mem_read_* / mem_write_* : per-channel memory ports (requests registered)
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDR_WIDTH    = $bits(data_memory_address_t),
  parameter int DATA_WIDTH    = $bits(data_t)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_read_addr,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_write_addr,
  input  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0] mem_write_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int ID_W = id_width(NUM_CONSUMERS);

  logic [NUM_CONSUMERS-1:0] busy;
  logic [ID_W-1:0]          rr_ptr;
  logic [ID_W-1:0]          rr_next;

  logic [NUM_CHANNELS-1:0]  ch_idle;
  logic [NUM_CHANNELS-1:0]  ch_grant;
  logic [NUM_CHANNELS-1:0]  ch_grant_read;
  logic [NUM_CHANNELS-1:0]  ch_owner_active;
  logic [NUM_CHANNELS-1:0]  ch_rd_done;
  logic [NUM_CHANNELS-1:0]  ch_wr_done;
  logic [NUM_CHANNELS-1:0]  ch_release;
  logic [ID_W-1:0]          ch_grant_id    [NUM_CHANNELS];
  logic [ID_W-1:0]          ch_owner       [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0]    ch_grant_addr  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]    ch_grant_wdata [NUM_CHANNELS];

  // Grant: channels in index order, each taking the first free requester from
  // rr_ptr onward; the claimed mask keeps two channels off the same consumer.
  logic [NUM_CONSUMERS-1:0] claimed;
  int                       max_id;

  always_comb begin
    claimed       = '0;
    ch_grant      = '0;
    ch_grant_read = '0;
    max_id        = -1;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_grant_id[c]    = '0;
      ch_grant_addr[c]  = '0;
      ch_grant_wdata[c] = '0;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        int idx;
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
        if (ch_idle[c] && !ch_grant[c] && !busy[idx] && !claimed[idx] &&
            (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
          ch_grant[c]       = 1'b1;
          claimed[idx]      = 1'b1;
          ch_grant_id[c]    = ID_W'(idx);
          // Read wins when both are raised; the write is picked up by a later grant.
          ch_grant_read[c]  = consumer_read_valid[idx];
          ch_grant_addr[c]  = consumer_read_valid[idx] ?
                              consumer_read_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] :
                              consumer_write_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
          ch_grant_wdata[c] = consumer_write_data[idx*DATA_WIDTH +: DATA_WIDTH];
          if (idx > max_id) max_id = idx;
        end
      end
    end
    rr_next = (max_id >= 0) ? ID_W'((max_id + 1) % NUM_CONSUMERS) : rr_ptr;
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_owner_active[c] = consumer_read_valid[ch_owner[c]] || consumer_write_valid[ch_owner[c]];
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mem_channel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ID_W       (ID_W)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .grant           (ch_grant[c]),
      .grant_is_read   (ch_grant_read[c]),
      .grant_id        (ch_grant_id[c]),
      .grant_addr      (ch_grant_addr[c]),
      .grant_wdata     (ch_grant_wdata[c]),
      .owner_active    (ch_owner_active[c]),
      .mem_read_valid  (mem_read_valid[c]),
      .mem_read_addr   (mem_read_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_read_ready  (mem_read_ready[c]),
      .mem_write_valid (mem_write_valid[c]),
      .mem_write_addr  (mem_write_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_write_data  (mem_write_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .mem_write_ready (mem_write_ready[c]),
      .owner           (ch_owner[c]),
      .idle            (ch_idle[c]),
      .rd_done         (ch_rd_done[c]),
      .wr_done         (ch_wr_done[c]),
      .release_done    (ch_release[c])
    );
  end

  // Consumer-side registers: ready pulses last one cycle, read data is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy                 <= '0;
      rr_ptr               <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      rr_ptr               <= rr_next;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (ch_rd_done[c]) begin
          consumer_read_ready[ch_owner[c]] <= 1'b1;
          consumer_read_data[ch_owner[c]*DATA_WIDTH +: DATA_WIDTH] <=
            mem_read_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
        if (ch_wr_done[c]) consumer_write_ready[ch_owner[c]] <= 1'b1;
        if (ch_release[c]) busy[ch_owner[c]] <= 1'b0;
        if (ch_grant[c])   busy[ch_grant_id[c]] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
module tb_data_mem_controller;

  localparam int N  = 8;
  localparam int NC = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   rv, wv, crr, cwr;
  logic [N*32-1:0] ra, wa, wdat, crd;
  logic [NC-1:0]  mrv, mwv, mrr, mwr;
  logic [NC*32-1:0] mra, mrd, mwa, mwd;

  data_mem_controller #(.NUM_CONSUMERS(N), .NUM_CHANNELS(NC), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_addr(ra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_addr(wa), .consumer_write_data(wdat),
    .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_addr(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_addr(mwa), .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: one transaction record per channel plus the consumer busy set.
  int          m_own [NC];
  bit          m_rd [NC], m_iss [NC], m_done [NC];
  logic [31:0] m_addr [NC], m_wd [NC];
  bit          m_busy [N];
  int          m_rr;
  bit          m_started = 0;
  logic [N-1:0] e_crr, e_cwr;
  logic [31:0] e_crd [N];
  logic [NC-1:0] e_mrv, e_mwv;
  logic [31:0] e_mra [NC], e_mwa [NC], e_mwd [NC];

  // LSU and memory stand-ins.
  logic [31:0] rd_addr [N], wr_addr [N], wr_data [N];
  int rd_left [N], wr_left [N], hold [N], cnt [N], rd_pulses [N], wr_pulses [N];
  bit pend [N];
  int rcnt [NC], wcnt [NC];
  int lat = 3;
  bit auto_resp = 1;
  logic [NC-1:0] prev_mrv, prev_mwv;
  int rd_issue = 0, wr_issue = 0;
  logic [31:0] order_q [$];
  int ord_ch_q [$];
  logic [31:0] w_seen_addr, w_seen_data;
  int w_seen_ch;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int gown [NC];
    bit claimed [N];
    int maxg, i;
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        m_own[c] = -1; m_rd[c] = 0; m_iss[c] = 0; m_done[c] = 0;
        e_mra[c] = '0; e_mwa[c] = '0; e_mwd[c] = '0;
      end
      for (int k = 0; k < N; k++) begin m_busy[k] = 0; e_crd[k] = '0; end
      m_rr = 0; e_crr = '0; e_cwr = '0; e_mrv = '0; e_mwv = '0;
      m_started = 1;
      return;
    end
    maxg = -1;
    for (int k = 0; k < N; k++) claimed[k] = 0;
    for (int c = 0; c < NC; c++) begin
      gown[c] = -1;
      if (m_own[c] < 0)
        for (int k = 0; k < N; k++) begin
          i = (m_rr + k) % N;
          if (gown[c] < 0 && (rv[i] || wv[i]) && !m_busy[i] && !claimed[i]) begin
            gown[c] = i; claimed[i] = 1;
            if (i > maxg) maxg = i;
          end
        end
    end
    e_crr = '0; e_cwr = '0;
    for (int c = 0; c < NC; c++) begin
      if (m_own[c] >= 0) begin
        if (!m_iss[c]) begin
          m_iss[c] = 1;
          if (m_rd[c]) begin e_mrv[c] = 1; e_mra[c] = m_addr[c]; end
          else begin e_mwv[c] = 1; e_mwa[c] = m_addr[c]; e_mwd[c] = m_wd[c]; end
        end else if (!m_done[c]) begin
          if (m_rd[c] && mrr[c]) begin
            e_crr[m_own[c]] = 1; e_crd[m_own[c]] = mrd[c*32 +: 32]; e_mrv[c] = 0; m_done[c] = 1;
          end else if (!m_rd[c] && mwr[c]) begin
            e_cwr[m_own[c]] = 1; e_mwv[c] = 0; m_done[c] = 1;
          end
        end else if (!rv[m_own[c]] && !wv[m_own[c]]) begin
          m_busy[m_own[c]] = 0; m_own[c] = -1;
        end
      end
    end
    for (int c = 0; c < NC; c++)
      if (gown[c] >= 0) begin
        i = gown[c];
        m_own[c] = i; m_rd[c] = rv[i]; m_iss[c] = 0; m_done[c] = 0; m_busy[i] = 1;
        m_addr[c] = rv[i] ? ra[i*32 +: 32] : wa[i*32 +: 32];
        m_wd[c] = wdat[i*32 +: 32];
      end
    if (maxg >= 0) m_rr = (maxg + 1) % N;
  endtask

  task automatic compare();
    logic [255:0] ecrd;
    logic [63:0] emra, emwa, emwd;
    if (!m_started) return;
    for (int k = 0; k < N; k++) ecrd[k*32 +: 32] = e_crd[k];
    for (int c = 0; c < NC; c++) begin
      emra[c*32 +: 32] = e_mra[c]; emwa[c*32 +: 32] = e_mwa[c]; emwd[c*32 +: 32] = e_mwd[c];
    end
    chk("consumer_read_ready", 256'(crr), 256'(e_crr));
    chk("consumer_write_ready", 256'(cwr), 256'(e_cwr));
    chk("consumer_read_data", crd, ecrd);
    chk("mem_read_valid", 256'(mrv), 256'(e_mrv));
    chk("mem_write_valid", 256'(mwv), 256'(e_mwv));
    chk("mem_read_addr", 256'(mra), 256'(emra));
    chk("mem_write_addr", 256'(mwa), 256'(emwa));
    chk("mem_write_data", 256'(mwd), 256'(emwd));
  endtask

  task automatic drop(input int i);
    rv[i] = 0; wv[i] = 0; pend[i] = 0;
  endtask

  task automatic lsu_update();
    for (int i = 0; i < N; i++) begin
      rd_pulses[i] += int'(crr[i]);
      wr_pulses[i] += int'(cwr[i]);
      if (rv[i] || wv[i]) begin
        if (pend[i]) begin
          cnt[i]--;
          if (cnt[i] <= 0) drop(i);
        end else if ((rv[i] && crr[i]) || (wv[i] && cwr[i])) begin
          if (hold[i] == 0) drop(i);
          else begin pend[i] = 1; cnt[i] = hold[i]; end
        end
      end else if (rd_left[i] > 0) begin
        rv[i] = 1; ra[i*32 +: 32] = rd_addr[i]; rd_left[i]--;
      end else if (wr_left[i] > 0) begin
        wv[i] = 1; wa[i*32 +: 32] = wr_addr[i]; wdat[i*32 +: 32] = wr_data[i]; wr_left[i]--;
      end
    end
  endtask

  task automatic mem_update();
    for (int c = 0; c < NC; c++) begin
      if (mrv[c] && !prev_mrv[c]) begin
        rd_issue++; order_q.push_back(mra[c*32 +: 32]); ord_ch_q.push_back(c);
      end
      if (mwv[c] && !prev_mwv[c]) begin
        wr_issue++; w_seen_addr = mwa[c*32 +: 32]; w_seen_data = mwd[c*32 +: 32]; w_seen_ch = c;
      end
      prev_mrv[c] = mrv[c]; prev_mwv[c] = mwv[c];
      if (mrr[c]) mrr[c] = 0;
      else if (auto_resp && mrv[c]) begin
        rcnt[c]++;
        if (rcnt[c] >= lat) begin mrr[c] = 1; mrd[c*32 +: 32] = mem_val(mra[c*32 +: 32]); rcnt[c] = 0; end
      end
      if (mwr[c]) mwr[c] = 0;
      else if (auto_resp && mwv[c]) begin
        wcnt[c]++;
        if (wcnt[c] >= lat) begin mwr[c] = 1; wcnt[c] = 0; end
      end
    end
  endtask

  // Inputs changed between ticks are what the next active edge samples.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
    lsu_update();
    mem_update();
  endtask

  task automatic start_read(input int i, input logic [31:0] a, input int reps, input int h);
    rd_addr[i] = a; rd_left[i] = reps; hold[i] = h;
  endtask

  task automatic start_write(input int i, input logic [31:0] a, input logic [31:0] d, input int h);
    wr_addr[i] = a; wr_data[i] = d; wr_left[i] = 1; hold[i] = h;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin rd_pulses[i] = 0; wr_pulses[i] = 0; end
    order_q.delete(); ord_ch_q.delete(); rd_issue = 0; wr_issue = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    for (int i = 0; i < N; i++) begin drop(i); rd_left[i] = 0; wr_left[i] = 0; end
    for (int c = 0; c < NC; c++) begin rcnt[c] = 0; wcnt[c] = 0; end
    tick(); tick();
    reset = 0;
  endtask

  task automatic wait_quiet(input int bound, input string name);
    int n, quiet;
    n = 0; quiet = 0;
    while (quiet < 3 && n < bound) begin
      tick(); n++;
      quiet = (rv == 0 && wv == 0 && mrv == 0 && mwv == 0) ? quiet + 1 : 0;
      for (int i = 0; i < N; i++) if (rd_left[i] > 0 || wr_left[i] > 0) quiet = 0;
    end
    if (quiet < 3) begin failures++; $display("FAIL %s timeout actual=busy required=quiet", name); end
  endtask

  task automatic wait_mem_read(input int bound, output int ch);
    int n;
    n = 0; ch = 0;
    while (mrv == 0 && n < bound) begin tick(); n++; end
    if (mrv == 0) begin failures++; $display("FAIL wait_mem_read timeout actual=0 required=1"); end
    else if (!mrv[0]) ch = 1;
  endtask

  initial begin
    int ch;
    reset = 1; rv = '0; wv = '0; ra = '0; wa = '0; wdat = '0;
    mrr = '0; mwr = '0; mrd = '0; prev_mrv = '0; prev_mwv = '0;
    w_seen_addr = '0; w_seen_data = '0; w_seen_ch = -1;
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
      rd_left[i] = 0; wr_left[i] = 0; hold[i] = 0; cnt[i] = 0; pend[i] = 0;
    end
    for (int c = 0; c < NC; c++) begin rcnt[c] = 0; wcnt[c] = 0; end
    clear_stats();
    do_reset();
    tick();
    chk("reset_outputs", 256'({crr, cwr, mrv, mwv}), 256'(0));
    chk("reset_read_data", crd, 256'(0));

    // Single read, memory answers after 3 cycles.
    start_read(3, 32'h40, 1, 0);
    wait_quiet(100, "single_read");
    chk("single_read_data", 256'(crd[3*32 +: 32]), 256'(32'hDEADBEEF));
    chk("single_read_pulses", 256'(rd_pulses[3]), 256'(1));
    chk("single_read_addr", 256'(order_q.size() > 0 ? order_q[0] : 32'hX), 256'(32'h40));
    chk("single_read_chan", 256'(ord_ch_q.size() > 0 ? ord_ch_q[0] : -1), 256'(0));

    // Single write.
    clear_stats();
    start_write(5, 32'h80, 32'h1234, 0);
    wait_quiet(100, "single_write");
    chk("write_pulses", 256'(wr_pulses[5]), 256'(1));
    chk("write_mem_count", 256'(wr_issue), 256'(1));
    chk("write_addr", 256'(w_seen_addr), 256'(32'h80));
    chk("write_data", 256'(w_seen_data), 256'(32'h1234));
    chk("write_chan", 256'(w_seen_ch), 256'(0));

    // Contention from rr_ptr=0: all eight consumers read together.
    do_reset();
    clear_stats();
    for (int i = 0; i < N; i++) start_read(i, 32'h100 + 32'(i) * 4, 1, 0);
    wait_quiet(400, "contention");
    chk("contention_count", 256'(order_q.size()), 256'(8));
    for (int k = 0; k < N; k++) begin
      chk("contention_order", 256'(k < order_q.size() ? order_q[k] : 32'hX), 256'(32'h100 + 32'(k) * 4));
      chk("contention_pulses", 256'(rd_pulses[k]), 256'(1));
    end

    // Fairness: 0,1,2 keep re-requesting while 7 asks once; 7 lands in round two.
    clear_stats();
    start_read(0, 32'h200, 4, 0);
    start_read(1, 32'h204, 4, 0);
    start_read(2, 32'h208, 4, 0);
    start_read(7, 32'h2E0, 1, 0);
    wait_quiet(600, "fairness");
    chk("fair_slot3", 256'(order_q.size() > 3 ? order_q[3] : 32'hX), 256'(32'h2E0));
    chk("fair_pulses0", 256'(rd_pulses[0]), 256'(4));
    chk("fair_pulses7", 256'(rd_pulses[7]), 256'(1));

    // Hold-off: valid stays up 3 cycles after ready; stray readies meanwhile.
    clear_stats();
    start_read(6, 32'h300, 1, 3);
    begin
      int n;
      n = 0;
      while (rd_pulses[6] == 0 && n < 100) begin tick(); n++; end
    end
    mrr = 2'b11; mrd = {32'hFFFFFFFF, 32'hFFFFFFFF};
    wait_quiet(100, "hold_off");
    chk("hold_issue_count", 256'(rd_issue), 256'(1));
    chk("hold_pulses", 256'(rd_pulses[6]), 256'(1));
    chk("hold_data", 256'(crd[6*32 +: 32]), 256'(32'h5A5A0300));

    // Wrong-type ready is ignored; then a manual read response.
    clear_stats();
    auto_resp = 0;
    start_read(4, 32'h44, 1, 0);
    wait_mem_read(50, ch);
    mwr[ch] = 1;
    tick(); tick();
    chk("wrong_type_pulses", 256'(rd_pulses[4]), 256'(0));
    mrr[ch] = 1; mrd[ch*32 +: 32] = 32'h0BADF00D;
    tick(); tick();
    chk("manual_data", 256'(crd[4*32 +: 32]), 256'(32'h0BADF00D));
    chk("manual_pulses", 256'(rd_pulses[4]), 256'(1));
    wait_quiet(50, "manual");

    // Reset during a read wait, then a late memory response.
    clear_stats();
    start_read(2, 32'h48, 1, 0);
    wait_mem_read(50, ch);
    do_reset();
    mrr[ch] = 1; mrd[ch*32 +: 32] = 32'h11111111;
    tick(); tick(); tick();
    chk("late_resp_pulses", 256'(rd_pulses[2]), 256'(0));
    chk("late_resp_outputs", 256'({crr, cwr, mrv, mwv}), 256'(0));
    chk("late_resp_data", crd, 256'(0));
    auto_resp = 1;
    start_read(2, 32'h4C, 1, 0);
    wait_quiet(100, "after_reset");
    chk("after_reset_pulses", 256'(rd_pulses[2]), 256'(1));
    chk("after_reset_data", 256'(crd[2*32 +: 32]), 256'(32'h5A5A004C));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
